// File: rtl/id_stage_p_if.sv
// id_stage_p_if: IF/ID inputs, WB write port and ID/EX outputs of
// the decode stage; master drives the pipeline, slave is the stage.
interface id_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              if_valid;
  logic [31:0]       instruction_in;
  logic [DATA_W-1:0] npc_in;
  logic              flush;
  logic              ex_stall;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              pc_write;
  logic              ifid_write;
  logic              ex_valid;
  logic              ex_branch_eq;
  logic              ex_branch_ne;
  logic              ex_jump;
  logic              ex_alusrc;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_regwrite;
  logic              ex_regdst;
  logic              ex_memtoreg;
  logic [2:0]        ex_aluop;
  logic              ex_illegal;
  logic [DATA_W-1:0] ex_npc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [25:0]       ex_jtarget;
`ifdef ID_PERF_CNT_EN
  logic [31:0]       hazard_cnt;
  logic [31:0]       flush_cnt;
`endif

  modport master (
    output if_valid, instruction_in, npc_in,
    output flush, ex_stall,
    output wb_we, wb_addr, wb_data,
    input  pc_write, ifid_write, ex_valid,
    input  ex_branch_eq, ex_branch_ne, ex_jump,
    input  ex_alusrc, ex_memread, ex_memwrite,
    input  ex_regwrite, ex_regdst, ex_memtoreg,
    input  ex_aluop, ex_illegal, ex_npc,
    input  ex_rs_data, ex_rt_data, ex_imm,
    input  ex_rs, ex_rt, ex_rd, ex_jtarget
`ifdef ID_PERF_CNT_EN
    ,
    input  hazard_cnt, flush_cnt
`endif
  );

  modport slave (
    input  if_valid, instruction_in, npc_in,
    input  flush, ex_stall,
    input  wb_we, wb_addr, wb_data,
    output pc_write, ifid_write, ex_valid,
    output ex_branch_eq, ex_branch_ne, ex_jump,
    output ex_alusrc, ex_memread, ex_memwrite,
    output ex_regwrite, ex_regdst, ex_memtoreg,
    output ex_aluop, ex_illegal, ex_npc,
    output ex_rs_data, ex_rt_data, ex_imm,
    output ex_rs, ex_rt, ex_rd, ex_jtarget
`ifdef ID_PERF_CNT_EN
    ,
    output hazard_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/id_stage_p.sv
// id_stage_p: MIPS decode stage - regfile with WB bypass, decoder,
// immediate extension, load-use detect, ID/EX register.
// Ports: CLK, RST (sync, active-high), bus (id_stage_p_if.slave).
// Optional ID_PERF_CNT_EN: hazard_cnt / flush_cnt on the bus.
module id_stage_p #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic         CLK,
  input logic         RST,
  id_stage_p_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;

  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             c;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [25:0]       jtarget;
  } id_ex_t;

  logic [DATA_W-1:0] rf [NREGS];
  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] imm_ext;
  logic is_r, is_lw, is_sw, is_beq, is_bne;
  logic is_addi, is_andi, is_ori, is_j;
  logic reads_rt, hazard, adv;
  ctrl_t  dec;
  id_ex_t d, q;

  assign op    = bus.instruction_in[31:26];
  assign rs    = bus.instruction_in[21 +: REG_AW];
  assign rt    = bus.instruction_in[16 +: REG_AW];
  assign rd    = bus.instruction_in[11 +: REG_AW];
  assign imm16 = bus.instruction_in[15:0];

  assign is_r    = op == 6'b000000;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_beq  = op == 6'b000100;
  assign is_bne  = op == 6'b000101;
  assign is_addi = op == 6'b001000;
  assign is_andi = op == 6'b001100;
  assign is_ori  = op == 6'b001101;
  assign is_j    = op == 6'b000010;

  assign reads_rt = is_r | is_sw | is_beq | is_bne;

  // WB write lands this edge, so reads see it through the bypass
  assign rs_val =
    (rs == '0) ? '0 :
    (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data :
    rf[rs];
  assign rt_val =
    (rt == '0) ? '0 :
    (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data :
    rf[rt];

  assign imm_ext = (is_andi | is_ori) ?
    DATA_W'(imm16) : DATA_W'($signed(imm16));

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b010;
      end
      is_lw: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      is_sw: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      is_beq: begin
        dec.branch_eq = 1'b1;
        dec.aluop     = 3'b001;
      end
      is_bne: begin
        dec.branch_ne = 1'b1;
        dec.aluop     = 3'b001;
      end
      is_addi: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      is_andi: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b011;
      end
      is_ori: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b100;
      end
      is_j:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // lw in EX whose destination is read here
  assign hazard = bus.if_valid && q.valid &&
    q.c.memread && q.rt != '0 &&
    (q.rt == rs || (reads_rt && q.rt == rt));

  always_comb begin
    d   = q;
    adv = 1'b1;
    if (bus.flush) begin
      d = '0;
    end else if (bus.ex_stall) begin
      adv = 1'b0;
    end else if (hazard) begin
      d   = '0;
      adv = 1'b0;
    end else begin
      d.valid   = bus.if_valid;
      d.c       = bus.if_valid ? dec : '0;
      d.npc     = bus.npc_in;
      d.rs_data = rs_val;
      d.rt_data = rt_val;
      d.imm     = imm_ext;
      d.rs      = rs;
      d.rt      = rt;
      d.rd      = rd;
      d.jtarget = bus.instruction_in[25:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) q <= '0;
    else     q <= d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != '0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.pc_write     = RST | adv;
  assign bus.ifid_write   = RST | adv;
  assign bus.ex_valid     = q.valid;
  assign bus.ex_branch_eq = q.c.branch_eq;
  assign bus.ex_branch_ne = q.c.branch_ne;
  assign bus.ex_jump      = q.c.jump;
  assign bus.ex_alusrc    = q.c.alusrc;
  assign bus.ex_memread   = q.c.memread;
  assign bus.ex_memwrite  = q.c.memwrite;
  assign bus.ex_regwrite  = q.c.regwrite;
  assign bus.ex_regdst    = q.c.regdst;
  assign bus.ex_memtoreg  = q.c.memtoreg;
  assign bus.ex_aluop     = q.c.aluop;
  assign bus.ex_illegal   = q.c.illegal;
  assign bus.ex_npc       = q.npc;
  assign bus.ex_rs_data   = q.rs_data;
  assign bus.ex_rt_data   = q.rt_data;
  assign bus.ex_imm       = q.imm;
  assign bus.ex_rs        = q.rs;
  assign bus.ex_rt        = q.rt;
  assign bus.ex_rd        = q.rd;
  assign bus.ex_jtarget   = q.jtarget;

`ifdef ID_PERF_CNT_EN
  logic [31:0] hz_cnt, fl_cnt;
  logic        hz_win;

  assign hz_win = !bus.flush && !bus.ex_stall && hazard;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hz_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (bus.flush && fl_cnt != '1)
        fl_cnt <= fl_cnt + 32'd1;
      if (hz_win && hz_cnt != '1)
        hz_cnt <= hz_cnt + 32'd1;
    end
  end

  assign bus.hazard_cnt = hz_cnt;
  assign bus.flush_cnt  = fl_cnt;
`endif
endmodule

// File: tb/tb_id_stage_p.sv
// tb_id_stage_p: self-checking bench for id_stage_p, directed
// scenarios plus random stimulus against a behavioural model.
module tb_id_stage_p;
  logic CLK = 1'b0;
  logic RST;
  int   total;
  int   bad;

  always #5 CLK = ~CLK;

  id_stage_p_if #(.DATA_W(32), .REG_AW(5)) bus ();
  id_stage_p_if #(.DATA_W(16), .REG_AW(3)) bus2 ();

  id_stage_p #(.DATA_W(32), .REG_AW(5)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  id_stage_p #(.DATA_W(16), .REG_AW(3)) dut16 (
    .CLK(CLK), .RST(RST), .bus(bus2)
  );

  // model state: architectural regs and expected ID/EX contents
  logic [31:0] ref_rf [32];
  logic        m_valid, m_known, m_pcw;
  logic [12:0] m_ctrl;
  logic [31:0] m_npc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [25:0] m_jt;
  logic        pcw_obs, ifw_obs;

  // control order: beq bne j alusrc mr mw rw regdst m2r aluop ill
  wire [12:0] d_ctrl = {
    bus.ex_branch_eq, bus.ex_branch_ne, bus.ex_jump,
    bus.ex_alusrc, bus.ex_memread, bus.ex_memwrite,
    bus.ex_regwrite, bus.ex_regdst, bus.ex_memtoreg,
    bus.ex_aluop, bus.ex_illegal};
  wire [168:0] d_data = {
    bus.ex_npc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
    bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_jtarget};
  wire [168:0] m_data = {
    m_npc, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_jt};

  function automatic logic [12:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 13'b0000001100100;
      6'h23:   return 13'b0001101010000;
      6'h2B:   return 13'b0001010000000;
      6'h04:   return 13'b1000000000010;
      6'h05:   return 13'b0100000000010;
      6'h08:   return 13'b0001001000000;
      6'h0C:   return 13'b0001001000110;
      6'h0D:   return 13'b0001001001000;
      6'h02:   return 13'b0010000000000;
      default: return 13'b0000000000001;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return ref_rf[a];
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  task automatic idle();
    bus.if_valid       = 1'b0;
    bus.instruction_in = 32'd0;
    bus.npc_in         = 32'd0;
    bus.flush          = 1'b0;
    bus.ex_stall       = 1'b0;
    bus.wb_we          = 1'b0;
    bus.wb_addr        = 5'd0;
    bus.wb_data        = 32'd0;
  endtask

  task automatic drive(input logic [31:0] ins);
    idle();
    bus.if_valid       = 1'b1;
    bus.instruction_in = ins;
    bus.npc_in         = $urandom;
  endtask

  // samples the combinational outputs, advances the model over one
  // rising edge and returns on the falling edge
  task automatic tick();
    logic [31:0] ins, rsv, rtv;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] im;
    logic        hz, rdr;
    #1;
    pcw_obs = bus.pc_write;
    ifw_obs = bus.ifid_write;
    ins = bus.instruction_in;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    im  = ins[15:0];
    rdr = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    hz  = bus.if_valid && m_valid && m_ctrl[8] &&
          m_rt != 5'd0 &&
          (m_rt == rs || (rdr && m_rt == rt));
    rsv = ref_read(rs);
    rtv = ref_read(rt);
    if (RST) begin
      m_pcw = 1'b1; m_valid = 1'b0; m_known = 1'b1;
      m_ctrl = '0; m_npc = '0; m_rsd = '0; m_rtd = '0;
      m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_jt = '0;
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    end else begin
      m_pcw = bus.flush || !(bus.ex_stall || hz);
      if (bus.flush || (!bus.ex_stall && hz)) begin
        m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
      end else if (!bus.ex_stall) begin
        m_valid = bus.if_valid;
        m_known = bus.if_valid;
        m_ctrl  = bus.if_valid ? ref_ctrl(op) : 13'd0;
        m_npc   = bus.npc_in;
        m_rsd   = rsv;
        m_rtd   = rtv;
        m_imm   = (op == 6'h0C || op == 6'h0D) ?
                  {16'h0, im} : {{16{im[15]}}, im};
        m_rs = rs; m_rt = rt; m_rd = ins[15:11];
        m_jt = ins[25:0];
      end
      if (bus.wb_we && bus.wb_addr != 5'd0)
        ref_rf[bus.wb_addr] = bus.wb_data;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.if_valid       = 1'b1;
      bus.instruction_in = $urandom;
      bus.npc_in         = $urandom;
      bus.flush          = 1'($urandom);
      bus.ex_stall       = 1'($urandom);
      bus.wb_we          = 1'b1;
      bus.wb_addr        = 5'($urandom);
      bus.wb_data        = $urandom;
      tick();
      total++;
      if ({pcw_obs, ifw_obs} !== 2'b11) begin
        bad++;
        $display("FAIL reset_pcw got=%b want=11",
                 {pcw_obs, ifw_obs});
      end
      total++;
      if ({bus.ex_valid, d_ctrl, d_data} !== '0) begin
        bad++;
        $display("FAIL reset_ex got=%b %h %h want=0",
                 bus.ex_valid, d_ctrl, d_data);
      end
    end
    RST = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(rtype(5'(i), 5'(31 - i), 5'd1));
      tick();
      total++;
      if ({bus.ex_rs_data, bus.ex_rt_data} !== 64'd0) begin
        bad++;
        $display("FAIL reset_reg r%0d got=%h %h want=0",
                 i, bus.ex_rs_data, bus.ex_rt_data);
      end
    end
  endtask

  task automatic test_bypass();
    idle(); tick();
    drive(rtype(5'd3, 5'd0, 5'd4));
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({bus.ex_rs_data, bus.ex_regdst, bus.ex_aluop} !==
        {32'hDEADBEEF, 1'b1, 3'b010}) begin
      bad++;
      $display("FAIL bypass got=%h rd=%b op=%b want=deadbeef 1 010",
               bus.ex_rs_data, bus.ex_regdst, bus.ex_aluop);
    end
    total++;
    if ({bus.ex_valid, d_ctrl} !== {m_valid, m_ctrl}) begin
      bad++;
      $display("FAIL bypass_ctrl got=%h want=%h",
               {bus.ex_valid, d_ctrl}, {m_valid, m_ctrl});
    end
    drive(rtype(5'd0, 5'd3, 5'd4));
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'h1234_5678;
    tick();
    total++;
    if ({bus.ex_rs_data, bus.ex_rt_data} !==
        {32'd0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL r0_write got=%h %h want=0 deadbeef",
               bus.ex_rs_data, bus.ex_rt_data);
    end
  endtask

  task automatic test_load_use();
    idle(); tick();
    drive(itype(6'h23, 5'd1, 5'd2, 16'd0));
    tick();
    drive(rtype(5'd2, 5'd3, 5'd5));
    tick();
    total++;
    if ({pcw_obs, ifw_obs, bus.ex_valid, d_ctrl} !== '0) begin
      bad++;
      $display("FAIL lu_stall got=%b%b v=%b c=%h want=0",
               pcw_obs, ifw_obs, bus.ex_valid, d_ctrl);
    end
    tick();
    total++;
    if ({pcw_obs, bus.ex_valid, bus.ex_rd, bus.ex_regdst} !==
        {1'b1, 1'b1, 5'd5, 1'b1}) begin
      bad++;
      $display("FAIL lu_issue got=%b %b %0d %b want=1 1 5 1",
               pcw_obs, bus.ex_valid, bus.ex_rd, bus.ex_regdst);
    end
    drive(itype(6'h23, 5'd1, 5'd2, 16'd0));
    tick();
    drive(itype(6'h08, 5'd4, 5'd2, 16'd7));
    tick();
    total++;
    if ({pcw_obs, bus.ex_valid} !== 2'b11) begin
      bad++;
      $display("FAIL lu_addi_rt got=%b want=11",
               {pcw_obs, bus.ex_valid});
    end
    drive(itype(6'h23, 5'd1, 5'd0, 16'd4));
    tick();
    drive(rtype(5'd0, 5'd0, 5'd6));
    tick();
    total++;
    if ({pcw_obs, bus.ex_valid} !== 2'b11) begin
      bad++;
      $display("FAIL lu_r0 got=%b want=11",
               {pcw_obs, bus.ex_valid});
    end
  endtask

  task automatic test_flush_stall();
    idle(); tick();
    drive(itype(6'h23, 5'd1, 5'd2, 16'd0));
    tick();
    drive(rtype(5'd2, 5'd3, 5'd5));
    bus.flush    = 1'b1;
    bus.ex_stall = 1'b1;
    tick();
    total++;
    if ({pcw_obs, ifw_obs, bus.ex_valid, d_ctrl} !==
        {2'b11, 14'd0}) begin
      bad++;
      $display("FAIL flush_win got=%b%b v=%b c=%h want=11 0 0",
               pcw_obs, ifw_obs, bus.ex_valid, d_ctrl);
    end
    drive(itype(6'h08, 5'd1, 5'd7, 16'd5));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive($urandom);
      bus.ex_stall = 1'b1;
      tick();
      total++;
      if ({pcw_obs, ifw_obs} !== 2'b00) begin
        bad++;
        $display("FAIL stall_pcw k=%0d got=%b want=00",
                 k, {pcw_obs, ifw_obs});
      end
      total++;
      if ({bus.ex_valid, d_ctrl, d_data} !==
          {m_valid, m_ctrl, m_data}) begin
        bad++;
        $display("FAIL stall_hold k=%0d got=%h %h want=%h %h",
                 k, d_ctrl, d_data, m_ctrl, m_data);
      end
    end
  endtask

  task automatic test_imm_illegal();
    idle(); tick();
    drive(itype(6'h0C, 5'd1, 5'd2, 16'h8001));
    tick();
    total++;
    if (bus.ex_imm !== 32'h0000_8001) begin
      bad++;
      $display("FAIL andi_imm got=%h want=00008001", bus.ex_imm);
    end
    drive(itype(6'h08, 5'd1, 5'd2, 16'h8001));
    tick();
    total++;
    if (bus.ex_imm !== 32'hFFFF_8001) begin
      bad++;
      $display("FAIL addi_imm got=%h want=ffff8001", bus.ex_imm);
    end
    drive(itype(6'h0D, 5'd1, 5'd2, 16'h8001));
    tick();
    total++;
    if (bus.ex_imm !== 32'h0000_8001) begin
      bad++;
      $display("FAIL ori_imm got=%h want=00008001", bus.ex_imm);
    end
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h1234));
    tick();
    total++;
    if ({bus.ex_valid, d_ctrl} !== {1'b1, 13'd1}) begin
      bad++;
      $display("FAIL illegal got=%b %b want=1 0000000000001",
               bus.ex_valid, d_ctrl);
    end
  endtask

  task automatic test_params();
    idle();
    bus2.wb_we   = 1'b1;
    bus2.wb_addr = 3'd3;
    bus2.wb_data = 16'h1234;
    tick();
    bus2.wb_addr = 3'd5;
    bus2.wb_data = 16'h00AA;
    bus2.if_valid = 1'b1;
    bus2.npc_in   = 16'hABCD;
    bus2.instruction_in =
      itype(6'h08, 5'b01011, 5'b11101, 16'h8001);
    tick();
    bus2.wb_we    = 1'b0;
    bus2.if_valid = 1'b0;
    total++;
    if ({bus2.ex_rs_data, bus2.ex_rt_data, bus2.ex_imm} !==
        {16'h1234, 16'h00AA, 16'h8001}) begin
      bad++;
      $display("FAIL p16_data got=%h %h %h want=1234 00aa 8001",
               bus2.ex_rs_data, bus2.ex_rt_data, bus2.ex_imm);
    end
    total++;
    if ({bus2.ex_valid, bus2.ex_alusrc, bus2.ex_rs,
         bus2.ex_rt, bus2.ex_npc} !==
        {2'b11, 3'd3, 3'd5, 16'hABCD}) begin
      bad++;
      $display("FAIL p16_fields got=%b%b rs=%0d rt=%0d npc=%h",
               bus2.ex_valid, bus2.ex_alusrc, bus2.ex_rs,
               bus2.ex_rt, bus2.ex_npc);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [9];
    int         sel;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
            6'h08, 6'h0C, 6'h0D, 6'h02};
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 10);
      bus.instruction_in = itype(
        (sel < 9) ? ops[sel] : 6'($urandom),
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        16'($urandom));
      if (sel == 10) bus.instruction_in[31:26] = 6'h23;
      bus.if_valid = $urandom_range(0, 7) != 0;
      bus.npc_in   = $urandom;
      bus.flush    = $urandom_range(0, 15) == 0;
      bus.ex_stall = $urandom_range(0, 7) == 0;
      bus.wb_we    = 1'($urandom);
      bus.wb_addr  = 5'($urandom_range(0, 3));
      bus.wb_data  = $urandom;
      tick();
      total++;
      if ({pcw_obs, ifw_obs} !== {m_pcw, m_pcw}) begin
        bad++;
        $display("FAIL rnd_pcw c=%0d got=%b%b want=%b",
                 c, pcw_obs, ifw_obs, m_pcw);
      end
      total++;
      if ({bus.ex_valid, d_ctrl} !== {m_valid, m_ctrl}) begin
        bad++;
        $display("FAIL rnd_ctrl c=%0d got=%h want=%h",
                 c, {bus.ex_valid, d_ctrl}, {m_valid, m_ctrl});
      end
      if (m_known) begin
        total++;
        if (d_data !== m_data) begin
          bad++;
          $display("FAIL rnd_data c=%0d got=%h want=%h",
                   c, d_data, m_data);
        end
      end
    end
  endtask

`ifdef ID_PERF_CNT_EN
  task automatic test_perf();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(itype(6'h23, 5'd1, 5'd2, 16'd0));
      tick();
      drive(rtype(5'd2, 5'd3, 5'd5));
      tick();
      tick();
    end
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    tick();
    total++;
    if ({bus.hazard_cnt, bus.flush_cnt} !== {32'd2, 32'd1}) begin
      bad++;
      $display("FAIL perf_cnt got=%0d %0d want=2 1",
               bus.hazard_cnt, bus.flush_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    idle();
    bus2.if_valid       = 1'b0;
    bus2.instruction_in = 32'd0;
    bus2.npc_in         = 16'd0;
    bus2.flush          = 1'b0;
    bus2.ex_stall       = 1'b0;
    bus2.wb_we          = 1'b0;
    bus2.wb_addr        = 3'd0;
    bus2.wb_data        = 16'd0;
    RST = 1'b1;
    @(negedge CLK);
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_imm_illegal();
    test_params();
    test_random();
`ifdef ID_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage_p.md
Name: id_stage_p

Overview:
- Parametrised instruction-decode stage for the 5-stage MIPS pipeline.
- Contains the register file with write-through bypass from WB, the opcode decoder, immediate extension, load-use hazard detection, and the ID/EX pipeline register.
- Adds what the previous decode stage lacked: a valid bit, flush, downstream stall, an illegal-opcode flag, and configurable data width and register count.

Parameters:
- DATA_W, 32, datapath width (≥16); immediates extend to this width; npc is this width.
- REG_AW, 5, register index width (1..5); NREGS = 2**REG_AW; the low REG_AW bits of each 5-bit instruction field are used.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- instruction_in  in  32  instruction word from IF/ID.
- npc_in  in  DATA_W  PC+4 from IF/ID.
- flush  in  1  taken branch/jump from EX; kill the instruction in ID.
- ex_stall  in  1  downstream stall; hold the ID/EX register.
- wb_we  in  1  WB register write enable.
- wb_addr  in  REG_AW  WB destination register.
- wb_data  in  DATA_W  WB write data.
- pc_write  out  1  PC may advance (combinational).
- ifid_write  out  1  IF/ID may load (combinational).
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_branch_eq, ex_branch_ne, ex_jump, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_regdst, ex_memtoreg  out  1 each  registered controls.
- ex_aluop  out  3  registered ALU op.
- ex_illegal  out  1  undecodable opcode.
- ex_npc  out  DATA_W  registered npc.
- ex_rs_data, ex_rt_data  out  DATA_W  registered operands.
- ex_imm  out  DATA_W  registered extended immediate.
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered register indices.
- ex_jtarget  out  26  instruction[25:0].

Behaviour:
- Reset: all ex_* outputs and all NREGS registers clear to 0. pc_write and ifid_write are 1 while RST is high.
- Register file: NREGS×DATA_W, written on the rising edge when wb_we && wb_addr!=0. Register 0 always reads 0.
- Write-through bypass: a read of index r returns wb_data when wb_we && wb_addr==r && r!=0.
- Decode (opcode = instruction[31:26]):
  - 000000 R-type: regdst=1, regwrite=1, aluop=010 (funct).
  - 100011 lw: alusrc, memread, memtoreg, regwrite; aluop=000.
  - 101011 sw: alusrc, memwrite; aluop=000.
  - 000100 beq: branch_eq; aluop=001.
  - 000101 bne: branch_ne; aluop=001.
  - 001000 addi: alusrc, regwrite; aluop=000.
  - 001100 andi: alusrc, regwrite; aluop=011.
  - 001101 ori: alusrc, regwrite; aluop=100.
  - 000010 j: jump.
  - Any other opcode: all controls 0, illegal=1.
- Immediate: zero-extended for andi/ori; sign-extended from bit 15 otherwise.
- Load-use hazard is asserted when all of the following hold:
  - if_valid && ex_valid && ex_memread && ex_rt!=0
  - and either ex_rt==rs, or ex_rt==rt for an opcode that reads rt (R-type, sw, beq, bne).
- Per-edge priority (highest first):
  - RST.
  - flush: ID/EX loads a bubble (ex_valid=0, all controls and ex_illegal 0, data don't-care); pc_write=1, ifid_write=1.
  - ex_stall: ID/EX holds its contents; pc_write=0, ifid_write=0.
  - hazard: ID/EX loads a bubble; pc_write=0, ifid_write=0, so the instruction is re-decoded next cycle.
  - normal: ID/EX loads the decode result with ex_valid=if_valid. When if_valid=0, controls are forced to 0. pc_write=1, ifid_write=1.
- Latency: 1 cycle from ID to the ex_* outputs.
- Hazard stall lasts exactly 1 cycle, because the bubble clears ex_memread.

Optional Feature:
- ID_PERF_CNT_EN defined:
  - Adds outputs hazard_cnt[31:0] and flush_cnt[31:0].
  - hazard_cnt increments on cycles where hazard is the winning priority case; flush_cnt increments on flush cycles.
  - Both saturate at 32'hFFFFFFFF and clear on RST.
- Not defined: the ports and counters do not exist.

Test Plan:
- Reset: hold RST 2 cycles with arbitrary inputs → all ex_* 0, pc_write=1, reads of r1..r31 return 0.
- Bypass: wb_we=1, wb_addr=3, wb_data=32'hDEAD_BEEF in the same cycle as decoding add $4,$3,$0 → next cycle ex_rs_data=32'hDEADBEEF, ex_regdst=1, ex_aluop=010. A write to r0 → reads 0.
- Load-use: lw $2,0($1) then add $5,$2,$3 →
  - cycle after lw enters EX: pc_write=0, ifid_write=0, bubble in ID/EX;
  - following cycle: add issues with ex_valid=1.
  - lw $0 followed by use of $0 → no stall.
- Flush vs stall: assert flush and ex_stall in the same cycle that hazard is true → bubble, pc_write=1. ex_stall alone for 3 cycles → ex_* unchanged, pc_write=0 throughout.
- Immediates/illegal:
  - andi with imm 16'h8001 → ex_imm=32'h00008001.
  - addi with imm 16'h8001 → ex_imm=32'hFFFF8001.
  - opcode 111111 → ex_illegal=1, all controls 0.
- Parameters: DATA_W=16, REG_AW=3 → instruction field 5'b01011 addresses r3; sign-extension is to 16 bits. With ID_PERF_CNT_EN defined, 2 hazards and 1 flush → hazard_cnt=2, flush_cnt=1.
